spi_accel_sequencer: RTL and testbench

//   Autonomous SPI master/sequencer for the board accelerometer (LIS3DH-class) on the SPI pins.

---
 rtl/spi_accel_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_spi_accel_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_sequencer.sv
// Autonomous SPI mode-3 master that identifies, configures and periodically polls an accelerometer.
// Latency: ID+CFG after reset, then one 56-bit burst read every POLL_DIV (+CLKDIV guard) clocks.
// Backpressure: none; start is honoured only while waiting, and samples are held until the next read.
//
// Ports:
//   clk, reset           single clock domain, synchronous active-high reset
//   start                1-cycle pulse, forces an immediate poll while waiting
//   spi_csn/sck/mosi     SPI master outputs (mode 3, MSB first), spi_miso input
//   accel_x/y/z          latest {H,L} samples, updated only by a completed read
//   sample_valid         1-cycle pulse coincident with the samples updating (csn rising)
//   id_ok / id_err       sticky WHO_AM_I result
//   busy                 mirrors ~spi_csn
module spi_accel_sequencer #(
  parameter int         CLKDIV    = 4,
  parameter int         POLL_DIV  = 100000,
  parameter logic [7:0] CTRL1_VAL = 8'h57,
  parameter logic [7:0] WHOAMI    = 8'h33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        id_ok,
  output logic        id_err,
  output logic        busy
);

  localparam int DW = $clog2(CLKDIV + 1);
  localparam int WW = $clog2(POLL_DIV + 1);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLKDIV - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    ST_ID,
    ST_CFG,
    ST_WAIT,
    ST_READ,
    ST_HALT
  } state_t;

  // Frame-engine phase. GAP is the csn-high guard that precedes every frame
  // (and the wait period); IDLE is the poll countdown proper.
  typedef enum logic [2:0] {
    PH_GAP,
    PH_IDLE,
    PH_SETUP,
    PH_LOW,
    PH_HIGH,
    PH_HOLD
  } phase_t;

  state_t state, state_nxt;
  phase_t phase, phase_nxt;

  logic [DW-1:0] div_cnt;
  logic [WW-1:0] wait_cnt;
  logic [5:0]    bit_cnt;
  logic [55:0]   tx_sr;
  logic [47:0]   rx_sr;

  logic          div_zero;
  logic          bit_zero;
  logic          wait_zero;
  logic          id_match;
  logic          frame_start;
  logic          frame_end;
  logic          sck_fall;
  logic          sck_rise;
  logic          wait_load;
  logic          sample_now;
  logic [55:0]   load_word;
  logic [5:0]    load_bits;

  assign div_zero   = (div_cnt == '0);
  assign bit_zero   = (bit_cnt == 6'd0);
  assign wait_zero  = (wait_cnt == '0);
  assign id_match   = (rx_sr[7:0] == WHOAMI);
  // MISO is captured in the first cycle that SCK is high.
  assign sample_now = (phase == PH_HIGH) && (div_cnt == DIV_LOAD);
  assign busy       = ~spi_csn;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ID;
      phase <= PH_GAP;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and frame-engine strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sck_fall    = 1'b0;
    sck_rise    = 1'b0;
    wait_load   = 1'b0;

    case (phase)
      PH_GAP: begin
        if (div_zero) begin
          if (state == ST_WAIT) begin
            phase_nxt = PH_IDLE;
            wait_load = 1'b1;
          end else if ((state == ST_ID) || (state == ST_CFG)) begin
            phase_nxt   = PH_SETUP;
            frame_start = 1'b1;
          end
          // ST_HALT: parked here with csn high until reset.
        end
      end
      PH_IDLE: begin
        // A start coinciding with expiry still yields a single read.
        if ((state == ST_WAIT) && (start || wait_zero)) begin
          state_nxt   = ST_READ;
          phase_nxt   = PH_SETUP;
          frame_start = 1'b1;
        end
      end
      PH_SETUP: begin
        if (div_zero) begin
          phase_nxt = PH_LOW;
          sck_fall  = 1'b1;
        end
      end
      PH_LOW: begin
        if (div_zero) begin
          phase_nxt = PH_HIGH;
          sck_rise  = 1'b1;
        end
      end
      PH_HIGH: begin
        if (div_zero) begin
          if (bit_zero) begin
            phase_nxt = PH_HOLD;
          end else begin
            phase_nxt = PH_LOW;
            sck_fall  = 1'b1;
          end
        end
      end
      PH_HOLD: begin
        if (div_zero) begin
          phase_nxt = PH_GAP;
          frame_end = 1'b1;
          case (state)
            ST_ID:   state_nxt = id_match ? ST_CFG : ST_HALT;
            ST_CFG:  state_nxt = ST_WAIT;
            ST_READ: state_nxt = ST_WAIT;
            default: state_nxt = state;
          endcase
        end
      end
      default: phase_nxt = PH_GAP;
    endcase
  end

  // Outgoing frame image, left-justified; trailing zeros keep MOSI low after
  // the command/data bits.
  always_comb begin
    load_word = {8'h8F, 48'd0};
    load_bits = 6'd15;
    case (state_nxt)
      ST_CFG: begin
        load_word = {8'h20, CTRL1_VAL, 40'd0};
        load_bits = 6'd15;
      end
      ST_READ: begin
        load_word = {8'hE8, 48'd0};
        load_bits = 6'd55;
      end
      default: begin
        load_word = {8'h8F, 48'd0};
        load_bits = 6'd15;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, shift registers, SPI pins and results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= DIV_LOAD;
      wait_cnt     <= '0;
      bit_cnt      <= 6'd0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      spi_csn      <= 1'b1;
      spi_sck      <= 1'b1;
      spi_mosi     <= 1'b0;
      accel_x      <= 16'd0;
      accel_y      <= 16'd0;
      accel_z      <= 16'd0;
      sample_valid <= 1'b0;
      id_ok        <= 1'b0;
      id_err       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;

      // Every phase change restarts the half-period divider.
      if (phase_nxt != phase) begin
        div_cnt <= DIV_LOAD;
      end else if (!div_zero) begin
        div_cnt <= div_cnt - DW'(1);
      end

      if (wait_load) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((phase == PH_IDLE) && !wait_zero) begin
        wait_cnt <= wait_cnt - WW'(1);
      end

      if (frame_start) begin
        spi_csn <= 1'b0;
        tx_sr   <= load_word;
        bit_cnt <= load_bits;
      end

      if (sck_fall) begin
        spi_sck  <= 1'b0;
        spi_mosi <= tx_sr[55];
        tx_sr    <= {tx_sr[54:0], 1'b0};
      end

      if (sck_rise) begin
        spi_sck <= 1'b1;
      end

      if ((phase == PH_HIGH) && div_zero && !bit_zero) begin
        bit_cnt <= bit_cnt - 6'd1;
      end

      if (sample_now) begin
        rx_sr <= {rx_sr[46:0], spi_miso};
      end

      if (frame_end) begin
        spi_csn  <= 1'b1;
        spi_mosi <= 1'b0;
        if (state == ST_ID) begin
          if (id_match) begin
            id_ok <= 1'b1;
          end else begin
            id_err <= 1'b1;
          end
        end
        // Byte order on the wire: XL,XH,YL,YH,ZL,ZH (command byte already shifted out).
        if (state == ST_READ) begin
          accel_x      <= {rx_sr[39:32], rx_sr[47:40]};
          accel_y      <= {rx_sr[23:16], rx_sr[31:24]};
          accel_z      <= {rx_sr[7:0],   rx_sr[15:8]};
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_accel_sequencer.sv
// Directed bench for spi_accel_sequencer with a behavioural mode-3 accelerometer model.
// Latency: frame-level checks on recorded csn-low windows; cycle counts from a posedge counter.
// Backpressure: n/a; the sensor model answers every frame it sees.
module tb_spi_accel_sequencer;

  localparam int CLKDIV   = 4;
  localparam int POLL_DIV = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        spi_miso = 1'b0;
  logic        spi_csn;
  logic        spi_sck;
  logic        spi_mosi;
  logic [15:0] accel_x;
  logic [15:0] accel_y;
  logic [15:0] accel_z;
  logic        sample_valid;
  logic        id_ok;
  logic        id_err;
  logic        busy;

  spi_accel_sequencer #(
    .CLKDIV   (CLKDIV),
    .POLL_DIV (POLL_DIV),
    .CTRL1_VAL(8'h57),
    .WHOAMI   (8'h33)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .spi_csn     (spi_csn),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .sample_valid(sample_valid),
    .id_ok       (id_ok),
    .id_err      (id_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Sensor model configuration (written only by the stimulus block).
  logic [7:0]  whoami_resp = 8'h33;
  logic [47:0] rd_resp = 48'd0;
  logic        mon_en = 1'b0;

  // Monitor / model state.
  logic        prev_csn = 1'b1;
  logic        prev_sck = 1'b1;
  logic        prev_mosi = 1'b0;
  int          nrise = 0;
  logic [63:0] sh = 64'd0;
  logic [7:0]  cmd = 8'd0;
  int          fstart = 0;
  int          last_rise = -1000;
  int          viol = 0;
  int          sv_cnt = 0;
  int          sv_bad = 0;

  int          fr_n = 0;
  int          fr_bits  [64];
  logic [63:0] fr_data  [64];
  int          fr_len   [64];
  int          fr_start [64];
  int          fr_end   [64];

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy !== ~spi_csn) viol++;
      if (spi_csn === 1'b1) begin
        if (spi_sck !== 1'b1) viol++;
        if (spi_mosi !== 1'b0) viol++;
        if (prev_csn && (spi_sck !== prev_sck)) viol++;
      end else if (prev_sck && spi_sck && (spi_mosi !== prev_mosi)) begin
        viol++;
      end
      if (!spi_csn && prev_csn && ((cyc - last_rise) < CLKDIV)) viol++;

      if (sample_valid) begin
        sv_cnt++;
        if (!(spi_csn && !prev_csn)) sv_bad++;
      end

      if (!spi_csn) begin
        if (prev_csn) begin
          fstart = cyc;
          nrise  = 0;
          sh     = 64'd0;
          cmd    = 8'd0;
        end
        if (!prev_sck && spi_sck) begin
          sh = {sh[62:0], spi_mosi};
          nrise++;
          if (nrise == 8) cmd = sh[7:0];
        end
        if (prev_sck && !spi_sck) begin
          if (nrise >= 8 && nrise < 16 && cmd == 8'h8F)
            spi_miso = whoami_resp[3'(15 - nrise)];
          else if (nrise >= 8 && nrise < 56 && cmd == 8'hE8)
            spi_miso = rd_resp[6'(55 - nrise)];
          else
            spi_miso = 1'b0;
        end
      end else if (!prev_csn) begin
        if (fr_n < 64) begin
          fr_bits[fr_n]  = nrise;
          fr_data[fr_n]  = sh;
          fr_len[fr_n]   = cyc - fstart;
          fr_start[fr_n] = fstart;
          fr_end[fr_n]   = cyc;
        end
        fr_n++;
        last_rise = cyc;
        spi_miso  = 1'b0;
      end
    end
    prev_csn  = spi_csn;
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (fr_n < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk(tag, 64'(fr_n >= n), 64'd1);
  endtask

  initial begin
    int n0;
    int sv0;
    int target;
    int low;
    int c;

    rd_resp = {8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h40};
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    // Reset state.
    chk("rst_pins",  64'({spi_csn, spi_sck, spi_mosi, busy}), 64'b1100);
    chk("rst_flags", 64'({sample_valid, id_ok, id_err}), 64'd0);
    chk("rst_accel", 64'({accel_x, accel_y, accel_z}), 64'd0);
    reset = 1'b0;

    // WHO_AM_I then CTRL_REG1.
    wait_frames(1, 1000, "id_frame_seen");
    chk("id_bits", 64'(fr_bits[0]), 64'd16);
    chk("id_mosi", fr_data[0], 64'h8F00);
    chk("id_len",  64'(fr_len[0]), 64'd136);
    chk("id_flags", 64'({id_ok, id_err}), 64'b10);
    wait_frames(2, 1000, "cfg_frame_seen");
    chk("cfg_bits", 64'(fr_bits[1]), 64'd16);
    chk("cfg_mosi", fr_data[1], 64'h2057);
    chk("cfg_len",  64'(fr_len[1]), 64'd136);

    // First burst read.
    wait_frames(3, 1500, "read1_seen");
    chk("rd_bits", 64'(fr_bits[2]), 64'd56);
    chk("rd_mosi", fr_data[2], 64'h00E8_0000_0000_0000);
    chk("rd_len",  64'(fr_len[2]), 64'd456);
    chk("rd_x", 64'(accel_x), 64'h1234);
    chk("rd_y", 64'(accel_y), 64'hFF80);
    chk("rd_z", 64'(accel_z), 64'h4000);
    chk("sv_cnt1", 64'(sv_cnt), 64'd1);

    // Second read with new data; samples must not move mid-frame.
    rd_resp = {8'h01, 8'h80, 8'hFF, 8'h00, 8'hFE, 8'h7F};
    c = 0;
    while (!(spi_csn === 1'b0 && nrise >= 40) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("mid_frame_reached", 64'(c < 2000), 64'd1);
    chk("no_partial_x", 64'(accel_x), 64'h1234);
    chk("no_partial_z", 64'(accel_z), 64'h4000);
    wait_frames(4, 1000, "read2_seen");
    chk("poll_gap", 64'(fr_start[3] - fr_end[2]), 64'(POLL_DIV + CLKDIV));
    chk("rd2_x", 64'(accel_x), 64'h8001);
    chk("rd2_y", 64'(accel_y), 64'h00FF);
    chk("rd2_z", 64'(accel_z), 64'h7FFE);
    chk("sv_cnt2", 64'(sv_cnt), 64'd2);

    // Start pulse while waiting.
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (spi_csn) @(negedge clk);
    chk("start_latency", 64'(spi_csn), 64'd0);
    wait_frames(5, 1000, "start_read_seen");
    chk("start_rd_bits", 64'(fr_bits[4]), 64'd56);
    chk("sv_cnt3", 64'(sv_cnt), 64'd3);

    // Start coinciding with counter expiry: one read, normal cadence.
    target = fr_end[4] + POLL_DIV + CLKDIV - 1;
    while (cyc < target) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frames(6, 1000, "coinc_read_seen");
    chk("coinc_gap", 64'(fr_start[5] - fr_end[4]), 64'(POLL_DIV + CLKDIV));
    wait_frames(7, 1000, "after_coinc_seen");
    chk("after_coinc_gap", 64'(fr_start[6] - fr_end[5]), 64'(POLL_DIV + CLKDIV));
    chk("sv_cnt4", 64'(sv_cnt), 64'd5);

    // Reset in the middle of a read (bit 30).
    c = 0;
    while (!(spi_csn === 1'b0 && nrise >= 30) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("bit30_reached", 64'(c < 2000), 64'd1);
    sv0 = sv_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pins",  64'({spi_csn, spi_sck, spi_mosi, busy}), 64'b1100);
    chk("midrst_flags", 64'({sample_valid, id_ok, id_err}), 64'd0);
    chk("midrst_accel", 64'({accel_x, accel_y, accel_z}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n0 = fr_n;
    wait_frames(n0 + 1, 1000, "restart_seen");
    chk("restart_mosi", fr_data[n0], 64'h8F00);
    chk("restart_bits", 64'(fr_bits[n0]), 64'd16);
    chk("abort_no_sv", 64'(sv_cnt), 64'(sv0));

    // Wrong WHO_AM_I: halt with csn high.
    whoami_resp = 8'h32;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n0 = fr_n;
    wait_frames(n0 + 1, 1000, "bad_id_seen");
    chk("bad_id_mosi", fr_data[n0], 64'h8F00);
    chk("bad_id_flags", 64'({id_ok, id_err}), 64'b01);
    low = 0;
    repeat (10000) begin
      @(negedge clk);
      if (spi_csn !== 1'b1) low++;
    end
    chk("halt_csn_low_cycles", 64'(low), 64'd0);
    chk("halt_frames", 64'(fr_n), 64'(n0 + 1));
    chk("halt_flags", 64'({id_ok, id_err}), 64'b01);

    chk("protocol_violations", 64'(viol), 64'd0);
    chk("sv_misaligned", 64'(sv_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
